config_table_sequencer: RTL

- Read-side engine for the per-rank configuration table.
- On start, walks table entries from start_add to end_add (inclusive, with wrap-around) and drives the table read address.
- Decodes each 21-bit control word plus its 512-bit immediate and issues one operation per entry on a valid/ready interface to the compute datapath.
- Stops early at the first entry whose valid bit is 0, or on abort.

---
 rtl/config_table_sequencer_pkg.sv | 37 +++
 rtl/config_table_sequencer_decode.sv | 18 +
 rtl/config_table_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/config_table_sequencer_pkg.sv
// Shared sizing, control-word layout and FSM state type for the configuration
// table read sequencer.
package config_table_sequencer_pkg;

    localparam int dwidth_RFadd = 4;
    localparam int depth_RF     = 16;
    localparam int phit_size    = 512;

    localparam int CTRL_W    = 21;
    localparam int VALID_BIT = 20;
    localparam int OP_HI     = 19;
    localparam int OP_LO     = 17;
    localparam int SRC1_HI   = 16;
    localparam int SRC1_LO   = 15;
    localparam int SRC2_HI   = 14;
    localparam int SRC2_LO   = 13;
    localparam int RW_BIT    = 12;
    localparam int ADDR_HI   = 11;
    localparam int ADDR_LO   = 0;

    typedef struct packed {
        logic        valid;
        logic [2:0]  op;
        logic [1:0]  src1;
        logic [1:0]  src2;
        logic        rw;
        logic [11:0] addr;
    } cfg_ctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        DONE
    } seq_state_t;

endpackage

// File: rtl/config_table_sequencer_decode.sv
// Combinational unpack of a 21-bit table control word into its named fields.
module cfg_ctrl_decode
    import config_table_sequencer_pkg::*;
(
    input  logic [CTRL_W-1:0] ctrl,
    output cfg_ctrl_t         fields
);

    always_comb begin
        fields.valid = ctrl[VALID_BIT];
        fields.op    = ctrl[OP_HI:OP_LO];
        fields.src1  = ctrl[SRC1_HI:SRC1_LO];
        fields.src2  = ctrl[SRC2_HI:SRC2_LO];
        fields.rw    = ctrl[RW_BIT];
        fields.addr  = ctrl[ADDR_HI:ADDR_LO];
    end

endmodule

// File: rtl/config_table_sequencer.sv
// Walks the configuration table from start_add to end_add (wrapping at depth_RF)
// and issues one decoded operation per valid entry over a valid/ready port.
module config_table_sequencer
    import config_table_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [dwidth_RFadd-1:0] start_add,
    input  logic [dwidth_RFadd-1:0] end_add,
    output logic [dwidth_RFadd-1:0] rd_add,
    input  logic [CTRL_W-1:0]       rd_data_ctrl,
    input  logic [phit_size-1:0]    rd_data_imm,
    output logic                    op_valid,
    input  logic                    op_ready,
    output logic [2:0]              op_code,
    output logic [1:0]              op_src1,
    output logic [1:0]              op_src2,
    output logic                    op_rw,
    output logic [11:0]             op_addr,
    output logic [phit_size-1:0]    op_imm,
    output logic                    busy,
    output logic                    done,
    output logic                    term_invalid,
    output logic [dwidth_RFadd:0]   issued_cnt
);

    seq_state_t              state, state_nxt;
    cfg_ctrl_t               dec;
    logic [dwidth_RFadd-1:0] end_lat;
    logic [dwidth_RFadd-1:0] add_inc;
    logic                    fire;
    logic                    at_end;

    cfg_ctrl_decode u_decode (
        .ctrl   (rd_data_ctrl),
        .fields (dec)
    );

    assign fire    = op_valid & op_ready;
    assign at_end  = (rd_add == end_lat);
    assign add_inc = (rd_add == dwidth_RFadd'(depth_RF - 1)) ? '0 : rd_add + 1'b1;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = FETCH;
                FETCH:   state_nxt = dec.valid ? ISSUE : DONE;
                ISSUE:   if (fire) state_nxt = at_end ? DONE : FETCH;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Captured op fields are frozen after FETCH, so later table rewrites never leak out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_add       <= '0;
            end_lat      <= '0;
            issued_cnt   <= '0;
            term_invalid <= 1'b0;
            op_valid     <= 1'b0;
            op_code      <= '0;
            op_src1      <= '0;
            op_src2      <= '0;
            op_rw        <= 1'b0;
            op_addr      <= '0;
            op_imm       <= '0;
        end else if (abort) begin
            op_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_add       <= start_add;
                        end_lat      <= end_add;
                        issued_cnt   <= '0;
                        term_invalid <= 1'b0;
                    end
                end
                FETCH: begin
                    op_code <= dec.op;
                    op_src1 <= dec.src1;
                    op_src2 <= dec.src2;
                    op_rw   <= dec.rw;
                    op_addr <= dec.addr;
                    op_imm  <= rd_data_imm;
                    if (dec.valid) op_valid     <= 1'b1;
                    else           term_invalid <= 1'b1;
                end
                ISSUE: begin
                    if (fire) begin
                        op_valid   <= 1'b0;
                        issued_cnt <= issued_cnt + 1'b1;
                        if (!at_end) rd_add <= add_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
